fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one 32-bit FIFO write port between N producers. Each producer offers data with a valid/ready handshake. The arbiter grants one owner at a time, holds that grant for up to BURST beats, and drives the FIFO's write_en/data_in. Backpressure comes from the FIFO's active-low full flag (1 = space available). It sits directly upstream of the FIFO.

Parameters:
N, 4, number of requesters (2..8)
DW, 32, data width; must match the FIFO data width
BURST, 4, maximum consecutive beats per grant (>=1; 1 = per-beat round robin)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req_valid  input  N  per-requester data valid
req_data  input  N*DW  requester i occupies bits [i*DW +: DW]
req_ready  output  N  per-requester accept; a beat transfers when valid & ready
fifo_full_n  input  1  FIFO full flag, active-low (1 = not full)
fifo_write_en  output  1  FIFO write strobe
fifo_data_in  output  DW  FIFO write data
grant_valid  output  1  an owner currently holds the grant
grant_id  output  clog2(N)  current owner index

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. Assertion clears all state immediately; deassertion is used synchronously to clk.
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0, beat_cnt = 0.
  - grant_valid = 0, grant_id = 0, req_ready = 0, fifo_write_en = 0, fifo_data_in = 0.
- FSM states: IDLE, OWN.
- IDLE:
  - If any req_valid is high, choose the first valid index searching upward from rr_ptr with wrap-around.
  - Register it as owner; next state OWN; beat_cnt = 0.
  - If no req_valid is high, stay in IDLE.
  - No transfers occur in IDLE.
- OWN outputs (combinational):
  - grant_valid = 1, grant_id = owner.
  - req_ready[owner] = fifo_full_n; all other req_ready bits = 0.
  - fifo_write_en = req_valid[owner] & fifo_full_n.
  - fifo_data_in = req_data[owner]. In IDLE, fifo_data_in = 0.
- OWN transitions, evaluated on each clk edge:
  - Beat written and beat_cnt == BURST-1: go to IDLE, rr_ptr = owner+1 mod N.
  - Beat written otherwise: beat_cnt++, stay in OWN.
  - req_valid[owner] low: go to IDLE, rr_ptr = owner+1 mod N. No beat is written that cycle.
  - req_valid[owner] high and fifo_full_n low: stall. Stay in OWN, beat_cnt held, no timeout.
- Latency and throughput:
  - First transfer happens the cycle after valid is seen in IDLE.
  - Each grant boundary costs exactly one IDLE cycle.
  - Peak throughput is BURST/(BURST+1) beats per cycle.
- Fairness: after an owner releases, every other continuously-valid requester is granted before that owner is granted again.
- A requester that drops valid before being granted is simply skipped.
- Width rules:
  - beat_cnt is max(1, clog2(BURST)) bits and never exceeds BURST-1.
  - rr_ptr and owner wrap modulo N; N is not required to be a power of two, so wrap explicitly.
- Reset mid-burst: fifo_write_en and req_ready drop asynchronously. A partially completed burst is abandoned, and no write occurs at the next edge.
- The arbiter never writes while fifo_full_n = 0. Writes are never duplicated or dropped: each accepted beat produces exactly one fifo_write_en cycle.

Decomposition:
- Package fifo_arb_pkg contains:
  - state enum: IDLE, OWN.
  - default constants: N_DEF = 4, DW_DEF = 32, BURST_DEF = 4.
  - width helper function: max(1, clog2(x)).
- Sub-module rr_pick: purely combinational.
  - Inputs: req vector (N), start pointer.
  - Outputs: found flag, index of first set bit at or after the pointer, with wrap-around.
  - Instantiated once in IDLE-path logic.

Test Plan:
1. rst_n = 0 while random req_valid is applied -> grant_valid, fifo_write_en and req_ready all 0; rr_ptr = 0. After release with only req 2 valid -> grant_id = 2 one cycle later.
2. BURST=4; req 1 holds valid for 6 beats (data 0x10..0x15), fifo_full_n = 1 -> four consecutive writes 0x10..0x13, one idle cycle, then re-grant to 1 and writes 0x14, 0x15.
3. BURST=1; all four requesters continuously valid -> grant order 0,1,2,3,0; fifo_write_en high every other cycle.
4. Mid-burst (owner 0, beat 1), fifo_full_n = 0 for 3 cycles -> fifo_write_en = 0, req_ready = 0, owner and beat_cnt unchanged. After full clears, writes resume and the burst completes with 4 total beats.
5. Owner 1 drops valid after 2 beats while reqs 0 and 2 are valid -> IDLE for one cycle, then grant to 2 (rr_ptr = 2), then 0.
6. rst_n asserted between clock edges during a burst -> fifo_write_en falls before the next edge; FIFO receives no further write. After release the state is IDLE and the first grant search starts from 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, default parameters and width helper for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam int unsigned N_DEF     = 4;
    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned BURST_DEF = 4;

    // Counter/index width that is never zero: max(1, clog2(x)).
    function automatic int unsigned clog2_min1(input int unsigned x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake bundle plus FIFO write port seen by the arbiter.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned DW = DW_DEF
);
    localparam int unsigned IW = clog2_min1(N);

    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full_n;
    logic            fifo_write_en;
    logic [DW-1:0]   fifo_data_in;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;

    // Arbiter side.
    modport master (
        input  req_valid, req_data, fifo_full_n,
        output req_ready, fifo_write_en, fifo_data_in, grant_valid, grant_id
    );

    // Producers / FIFO side.
    modport slave (
        output req_valid, req_data, fifo_full_n,
        input  req_ready, fifo_write_en, fifo_data_in, grant_valid, grant_id
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit at or after start, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic [N-1:0]               req,
    input  logic [clog2_min1(N)-1:0]   start,
    output logic                       found,
    output logic [clog2_min1(N)-1:0]   idx
);
    localparam int unsigned IW = clog2_min1(N);

    int p;

    // Scan offsets from far to near so the nearest set bit wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        p     = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            p = int'(start) + k;
            if (p >= int'(N)) begin
                p = p - int'(N);
            end
            if (req[IW'(p)]) begin
                found = 1'b1;
                idx   = IW'(p);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N producers, with
// grants held for up to BURST beats and one idle cycle between grants.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned BURST = BURST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int unsigned    IW        = clog2_min1(N);
    localparam int unsigned    BW        = clog2_min1(BURST);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BURST - 1);
    localparam logic [IW-1:0]  LAST_IDX  = IW'(N - 1);

    state_t         state, state_nxt;
    logic [IW-1:0]  rr_ptr, rr_ptr_nxt;
    logic [IW-1:0]  owner, owner_nxt;
    logic [BW-1:0]  beat_cnt, beat_cnt_nxt;

    logic           pick_found;
    logic [IW-1:0]  pick_idx;
    logic [IW-1:0]  owner_inc;
    logic [DW-1:0]  slot [N];

    logic [N-1:0]   ready;
    logic           write_en;
    logic [DW-1:0]  data_in;
    logic           gnt_valid;
    logic [IW-1:0]  gnt_id;

    rr_pick #(.N(N)) u_pick (
        .req   (bus.req_valid),
        .start (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Unpack the flat producer data bus into per-requester lanes.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            slot[i] = bus.req_data[i*DW +: DW];
        end
    end

    assign owner_inc = (owner == LAST_IDX) ? '0 : owner + IW'(1);

    // State register; reset abandons any burst in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // Next-state and grant/write outputs.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        beat_cnt_nxt = beat_cnt;
        gnt_valid    = 1'b0;
        gnt_id       = '0;
        ready        = '0;
        write_en     = 1'b0;
        data_in      = '0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nxt    = pick_idx;
                    beat_cnt_nxt = '0;
                    state_nxt    = OWN;
                end
            end
            OWN: begin
                gnt_valid    = 1'b1;
                gnt_id       = owner;
                ready[owner] = bus.fifo_full_n;
                write_en     = bus.req_valid[owner] & bus.fifo_full_n;
                data_in      = slot[owner];
                if (!bus.req_valid[owner]) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = owner_inc;
                end else if (bus.fifo_full_n) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt  = IDLE;
                        rr_ptr_nxt = owner_inc;
                    end else begin
                        beat_cnt_nxt = beat_cnt + BW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.req_ready     = ready;
    assign bus.fifo_write_en = write_en;
    assign bus.fifo_data_in  = data_in;
    assign bus.grant_valid   = gnt_valid;
    assign bus.grant_id      = gnt_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (BURST=4 and BURST=1 instances).
module tb_fifo_wr_arbiter;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter_if #(.N(4), .DW(32)) bus4 ();
    fifo_wr_arbiter_if #(.N(4), .DW(32)) bus1 ();

    fifo_wr_arbiter #(.N(4), .DW(32), .BURST(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    fifo_wr_arbiter #(.N(4), .DW(32), .BURST(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          sel;   // 0: BURST=4 instance, 1: BURST=1 instance
        logic [3:0]  rv;
        logic        fn;
        logic [31:0] d;
        logic        gv;
        logic [1:0]  gid;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit sel, logic [3:0] rv, logic fn, logic [31:0] d,
                                logic gv, logic [1:0] gid, logic we, logic [31:0] wd,
                                logic [3:0] rdy);
        vec_t v;
        v.rst = rst; v.sel = sel; v.rv = rv; v.fn = fn; v.d = d;
        v.gv = gv; v.gid = gid; v.we = we; v.wd = wd; v.rdy = rdy;
        return v;
    endfunction

    // Lane i carries d + i*0x100 so the selected owner is visible in the data.
    task automatic apply(input logic [3:0] rv, input logic fn, input logic [31:0] d);
        bus4.req_valid   = rv;
        bus1.req_valid   = rv;
        bus4.fifo_full_n = fn;
        bus1.fifo_full_n = fn;
        for (int i = 0; i < 4; i++) begin
            bus4.req_data[i*32 +: 32] = d + 32'(i * 256);
            bus1.req_data[i*32 +: 32] = d + 32'(i * 256);
        end
    endtask

    task automatic check(input string name, input bit sel, input logic gv, input logic [1:0] gid,
                         input logic we, input logic [31:0] wd, input logic [3:0] rdy);
        logic [39:0] act;
        logic [39:0] exp;
        if (sel)
            act = {bus1.grant_valid, bus1.grant_id, bus1.fifo_write_en, bus1.fifo_data_in, bus1.req_ready};
        else
            act = {bus4.grant_valid, bus4.grant_id, bus4.fifo_write_en, bus4.fifo_data_in, bus4.req_ready};
        exp = {gv, gid, we, wd, rdy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gv=%0b id=%0d we=%0b data=%h ready=%b, want gv=%0b id=%0d we=%0b data=%h ready=%b",
                     name, act[39], act[38:37], act[36], act[35:4], act[3:0],
                     gv, gid, we, wd, rdy);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        apply(4'b0000, 1'b1, 32'h0);

        // Burst of 4 then one idle cycle, re-grant to the same sole requester.
        tbl.push_back(mk(1, 0, 4'b0010, 1, 32'h10, 0, 0, 0, 32'h0,   4'b0000));
        tbl.push_back(mk(0, 0, 4'b0010, 1, 32'h10, 1, 1, 1, 32'h110, 4'b0010));
        tbl.push_back(mk(0, 0, 4'b0010, 1, 32'h11, 1, 1, 1, 32'h111, 4'b0010));
        tbl.push_back(mk(0, 0, 4'b0010, 1, 32'h12, 1, 1, 1, 32'h112, 4'b0010));
        tbl.push_back(mk(0, 0, 4'b0010, 1, 32'h13, 1, 1, 1, 32'h113, 4'b0010));
        tbl.push_back(mk(0, 0, 4'b0010, 1, 32'h14, 0, 0, 0, 32'h0,   4'b0000));
        tbl.push_back(mk(0, 0, 4'b0010, 1, 32'h14, 1, 1, 1, 32'h114, 4'b0010));
        tbl.push_back(mk(0, 0, 4'b0010, 1, 32'h15, 1, 1, 1, 32'h115, 4'b0010));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 32'h15, 1, 1, 0, 32'h115, 4'b0010));
        tbl.push_back(mk(0, 0, 4'b0000, 1, 32'h15, 0, 0, 0, 32'h0,   4'b0000));
        // BURST=1 per-beat round robin over four busy requesters.
        tbl.push_back(mk(1, 1, 4'b1111, 1, 32'h20, 0, 0, 0, 32'h0,   4'b0000));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 32'h20, 1, 0, 1, 32'h20,  4'b0001));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 32'h20, 0, 0, 0, 32'h0,   4'b0000));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 32'h20, 1, 1, 1, 32'h120, 4'b0010));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 32'h20, 0, 0, 0, 32'h0,   4'b0000));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 32'h20, 1, 2, 1, 32'h220, 4'b0100));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 32'h20, 0, 0, 0, 32'h0,   4'b0000));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 32'h20, 1, 3, 1, 32'h320, 4'b1000));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 32'h20, 0, 0, 0, 32'h0,   4'b0000));
        tbl.push_back(mk(0, 1, 4'b1111, 1, 32'h20, 1, 0, 1, 32'h20,  4'b0001));
        // FIFO full for 3 cycles at beat 1; burst still totals 4 beats.
        tbl.push_back(mk(1, 0, 4'b0001, 1, 32'h30, 0, 0, 0, 32'h0,   4'b0000));
        tbl.push_back(mk(0, 0, 4'b0001, 1, 32'h30, 1, 0, 1, 32'h30,  4'b0001));
        tbl.push_back(mk(0, 0, 4'b0001, 0, 32'h31, 1, 0, 0, 32'h31,  4'b0000));
        tbl.push_back(mk(0, 0, 4'b0001, 0, 32'h31, 1, 0, 0, 32'h31,  4'b0000));
        tbl.push_back(mk(0, 0, 4'b0001, 0, 32'h31, 1, 0, 0, 32'h31,  4'b0000));
        tbl.push_back(mk(0, 0, 4'b0001, 1, 32'h31, 1, 0, 1, 32'h31,  4'b0001));
        tbl.push_back(mk(0, 0, 4'b0001, 1, 32'h32, 1, 0, 1, 32'h32,  4'b0001));
        tbl.push_back(mk(0, 0, 4'b0001, 1, 32'h33, 1, 0, 1, 32'h33,  4'b0001));
        tbl.push_back(mk(0, 0, 4'b0001, 1, 32'h34, 0, 0, 0, 32'h0,   4'b0000));
        // Owner 1 drops valid after 2 beats; grant moves to 2, then wraps to 0.
        tbl.push_back(mk(1, 0, 4'b0010, 1, 32'h40, 0, 0, 0, 32'h0,   4'b0000));
        tbl.push_back(mk(0, 0, 4'b0111, 1, 32'h40, 1, 1, 1, 32'h140, 4'b0010));
        tbl.push_back(mk(0, 0, 4'b0111, 1, 32'h41, 1, 1, 1, 32'h141, 4'b0010));
        tbl.push_back(mk(0, 0, 4'b0101, 1, 32'h41, 1, 1, 0, 32'h141, 4'b0010));
        tbl.push_back(mk(0, 0, 4'b0101, 1, 32'h42, 0, 0, 0, 32'h0,   4'b0000));
        tbl.push_back(mk(0, 0, 4'b0101, 1, 32'h42, 1, 2, 1, 32'h242, 4'b0100));
        tbl.push_back(mk(0, 0, 4'b0001, 1, 32'h42, 1, 2, 0, 32'h242, 4'b0100));
        tbl.push_back(mk(0, 0, 4'b0001, 1, 32'h42, 0, 0, 0, 32'h0,   4'b0000));
        tbl.push_back(mk(0, 0, 4'b0001, 1, 32'h42, 1, 0, 1, 32'h42,  4'b0001));

        // Reset held while requests toggle: everything stays quiet.
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            apply(4'($urandom_range(0, 15)), 1'b1, $urandom);
            @(negedge clk);
            check($sformatf("rst_hold%0d_b4", c), 0, 0, 0, 0, 32'h0, 4'b0000);
            check($sformatf("rst_hold%0d_b1", c), 1, 0, 0, 0, 32'h0, 4'b0000);
        end
        @(posedge clk);
        #1;
        apply(4'b0100, 1'b1, 32'h70);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_idle", 0, 0, 0, 0, 32'h0, 4'b0000);
        @(negedge clk);
        check("rst_release_grant2", 0, 1, 2, 1, 32'h270, 4'b0100);

        // Table vectors.
        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            if (tbl[k].rst) begin
                rst_n = 1'b0;
                #2;
                rst_n = 1'b1;
            end
            apply(tbl[k].rv, tbl[k].fn, tbl[k].d);
            @(negedge clk);
            check($sformatf("vec%0d", k), tbl[k].sel, tbl[k].gv, tbl[k].gid,
                  tbl[k].we, tbl[k].wd, tbl[k].rdy);
        end

        // Asynchronous reset in the middle of a burst.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        apply(4'b0001, 1'b1, 32'h50);
        @(negedge clk);
        check("midrst_idle", 0, 0, 0, 0, 32'h0, 4'b0000);
        @(negedge clk);
        check("midrst_beat0", 0, 1, 0, 1, 32'h50, 4'b0001);
        @(posedge clk);
        #1;
        apply(4'b0001, 1'b1, 32'h51);
        #1;
        check("midrst_beat1", 0, 1, 0, 1, 32'h51, 4'b0001);
        rst_n = 1'b0;
        #1;
        check("midrst_async_drop", 0, 0, 0, 0, 32'h0, 4'b0000);
        @(posedge clk);
        #1;
        check("midrst_no_write", 0, 0, 0, 0, 32'h0, 4'b0000);
        apply(4'b0011, 1'b1, 32'h60);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_post_idle", 0, 0, 0, 0, 32'h0, 4'b0000);
        @(negedge clk);
        check("midrst_post_grant0", 0, 1, 0, 1, 32'h60, 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
